// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size/state encodings,
// alignment check and byte-enable generation.
package lsu_pkg;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} lsu_size_t;
    typedef enum logic [1:0] {LSU_IDLE, LSU_BUSY, LSU_DONE} lsu_state_t;

    localparam int NUM_LANES = 4;

    function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [NUM_LANES-1:0] byte_enable(input lsu_size_t size, input logic [1:0] offset);
        logic [NUM_LANES-1:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = 4'b0011 << offset;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the addressed lane out of the read word
// and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  lsu_size_t   i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    // Halves are only ever accessed at offsets 0 or 2, so offset[1] picks the lane.
    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    always_comb begin
        o_data = '0;
        w_sign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                w_sign = ~i_unsigned & w_byte[7];
                o_data = {{24{w_sign}}, w_byte};
            end
            SZ_HALF: begin
                w_sign = ~i_unsigned & w_half[15];
                o_data = {{16{w_sign}}, w_half};
            end
            SZ_WORD: o_data = i_rdata;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: latches a core request, runs one word-aligned
// memory access under a req/ready handshake, and stalls the core until done.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    input  logic                 i_req_we,
    input  logic [1:0]           i_req_size,
    input  logic                 i_req_unsigned,
    input  logic [ADDR_W-1:0]    i_req_addr,
    input  logic [DATA_W-1:0]    i_req_wdata,
    output logic                 o_stall,
    output logic [DATA_W-1:0]    o_load_data,
    output logic                 o_load_valid,
    output logic                 o_fault,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [NUM_LANES-1:0] o_mem_be,
    output logic [DATA_W-1:0]    o_mem_wdata,
    input  logic                 i_mem_ready,
    input  logic [DATA_W-1:0]    i_mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_we;
    logic              r_uns;
    lsu_size_t         r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_load_data;

    lsu_size_t         w_req_size;
    logic              w_err;
    logic              w_latch;
    logic              w_capture;
    logic [DATA_W-1:0] w_aligned;

    assign w_req_size = lsu_size_t'(i_req_size);
    assign w_err      = is_misaligned(w_req_size, i_req_addr[1:0]);

    lsu_load_align u_align (
        .i_rdata    (i_mem_rdata),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_aligned)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_stall      = 1'b0;
        o_fault      = 1'b0;
        o_mem_req    = 1'b0;
        o_load_valid = 1'b0;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (i_req_valid) begin
                    if (w_err) begin
                        o_fault = 1'b1;
                    end else begin
                        w_latch = 1'b1;
                        o_stall = 1'b1;
                        w_next  = LSU_BUSY;
                    end
                end
            end
            LSU_BUSY: begin
                o_mem_req = 1'b1;
                o_stall   = 1'b1;
                if (i_mem_ready) begin
                    w_capture = ~r_we;
                    w_next    = LSU_DONE;
                end
            end
            LSU_DONE: begin
                // The core still presents the completing instruction here; it must not re-issue.
                o_load_valid = ~r_we;
                w_next       = LSU_IDLE;
            end
            default: w_next = LSU_IDLE;
        endcase
        if (i_rst) begin
            o_stall      = 1'b0;
            o_fault      = 1'b0;
            o_mem_req    = 1'b0;
            o_load_valid = 1'b0;
            w_latch      = 1'b0;
            w_capture    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_size      <= SZ_BYTE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_load_data <= '0;
        end else begin
            if (w_latch) begin
                r_we    <= i_req_we;
                r_uns   <= i_req_unsigned;
                r_size  <= w_req_size;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end
            if (w_capture) begin
                r_load_data <= w_aligned;
            end
        end
    end

    always_comb begin
        case (r_size)
            SZ_BYTE: o_mem_wdata = {4{r_wdata[7:0]}};
            SZ_HALF: o_mem_wdata = {2{r_wdata[15:0]}};
            default: o_mem_wdata = r_wdata;
        endcase
    end

    assign o_mem_we    = r_we;
    assign o_mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_mem_be    = r_we ? byte_enable(r_size, r_addr[1:0]) : '0;
    assign o_load_data = o_fault ? '0 : r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Observations recorded by run_access
    logic        ob_first_stall, ob_first_fault, ob_we, ob_lv, ob_req_after, ob_lv_after, ob_stable, ob_lv_early;
    logic [31:0] ob_addr, ob_wdata, ob_ld;
    logic [3:0]  ob_be;
    int          ob_busy, ob_stall_cycles, ob_latency;

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_stall        (stall),
        .o_load_data    (load_data),
        .o_load_valid   (load_valid),
        .o_fault        (fault),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_be       (mem_be),
        .o_mem_wdata    (mem_wdata),
        .i_mem_ready    (mem_ready),
        .i_mem_rdata    (mem_rdata)
    );

    // Drives one request, holds req_valid until stall falls, answers after 'waits' BUSY cycles.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; mem_ready = 1'b0; mem_rdata = rdata;
        #1;
        ob_first_stall = stall; ob_first_fault = fault;
        ob_busy = 0; ob_stable = 1'b1; ob_lv = 1'b0; ob_ld = '0; ob_lv_early = 1'b0;
        ob_stall_cycles = stall ? 1 : 0;
        cyc = 1;
        if (stall) begin
            while (cyc < 40) begin
                @(negedge clk);
                cyc++;
                mem_ready = (ob_busy >= waits);
                #1;
                if (mem_req) begin
                    if (ob_busy == 0) begin
                        ob_addr = mem_addr; ob_be = mem_be; ob_wdata = mem_wdata; ob_we = mem_we;
                    end else if (mem_addr !== ob_addr || mem_be !== ob_be || mem_wdata !== ob_wdata) begin
                        ob_stable = 1'b0;
                    end
                    ob_busy++;
                    if (load_valid) ob_lv_early = 1'b1;
                end
                if (stall) ob_stall_cycles++;
                else begin
                    ob_lv = load_valid; ob_ld = load_data;
                    break;
                end
            end
            if (cyc >= 40) begin
                errors++;
                $display("FAIL timeout: stall still %b after %0d cycles, required to fall", stall, cyc);
            end
        end
        ob_latency = cyc;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b0;
        #1;
        ob_req_after = mem_req; ob_lv_after = load_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = '0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (mem_req !== 1'b0)    begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (fault !== 1'b0)      begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL reset_load_valid: got %b want 0", load_valid); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data: got %h want 0", load_data); end
        req_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lw;
        run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        checks++; if (ob_first_stall !== 1'b1) begin errors++; $display("FAIL lw_stall_idle: got %b want 1", ob_first_stall); end
        checks++; if (ob_addr !== 32'h100)     begin errors++; $display("FAIL lw_addr: got %h want 00000100", ob_addr); end
        checks++; if (ob_be !== 4'b0000)       begin errors++; $display("FAIL lw_be: got %b want 0000", ob_be); end
        checks++; if (ob_we !== 1'b0)          begin errors++; $display("FAIL lw_we: got %b want 0", ob_we); end
        checks++; if (ob_stall_cycles != 2)    begin errors++; $display("FAIL lw_stall_cycles: got %0d want 2", ob_stall_cycles); end
        checks++; if (ob_latency != 3)         begin errors++; $display("FAIL lw_latency: got %0d want 3", ob_latency); end
        checks++; if (ob_lv !== 1'b1)          begin errors++; $display("FAIL lw_load_valid: got %b want 1", ob_lv); end
        checks++; if (ob_ld !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_load_data: got %h want deadbeef", ob_ld); end
        checks++; if (ob_req_after !== 1'b0)   begin errors++; $display("FAIL lw_no_reissue: mem_req %b want 0", ob_req_after); end
        checks++; if (ob_lv_after !== 1'b0)    begin errors++; $display("FAIL lw_lv_pulse: load_valid %b want 0", ob_lv_after); end
    endtask

    task automatic test_lb_lbu;
        run_access(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF_0000, 0);
        checks++; if (ob_addr !== 32'h200)     begin errors++; $display("FAIL lb_addr: got %h want 00000200", ob_addr); end
        checks++; if (ob_ld !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", ob_ld); end
        run_access(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF_0000, 0);
        checks++; if (ob_ld !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", ob_ld); end
        run_access(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h80FF_0000, 0);
        checks++; if (ob_ld !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_data: got %h want ffff80ff", ob_ld); end
        run_access(1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'h1234_8001, 0);
        checks++; if (ob_ld !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: got %h want 00008001", ob_ld); end
    endtask

    task automatic test_sh;
        run_access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD, 32'h0, 0);
        checks++; if (ob_addr !== 32'h10)      begin errors++; $display("FAIL sh_addr: got %h want 00000010", ob_addr); end
        checks++; if (ob_be !== 4'b1100)       begin errors++; $display("FAIL sh_be: got %b want 1100", ob_be); end
        checks++; if (ob_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", ob_wdata); end
        checks++; if (ob_we !== 1'b1)          begin errors++; $display("FAIL sh_we: got %b want 1", ob_we); end
        checks++; if (ob_lv !== 1'b0 || ob_lv_early !== 1'b0) begin errors++; $display("FAIL sh_load_valid: got %b want 0", ob_lv | ob_lv_early); end
        checks++; if (ob_latency != 3)         begin errors++; $display("FAIL sh_latency: got %0d want 3", ob_latency); end
        run_access(1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_5677, 32'h0, 0);
        checks++; if (ob_be !== 4'b0010 || ob_wdata !== 32'h7777_7777) begin errors++; $display("FAIL sb_be_wdata: got %b/%h want 0010/77777777", ob_be, ob_wdata); end
        run_access(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0, 0);
        checks++; if (ob_be !== 4'b1111 || ob_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_be_wdata: got %b/%h want 1111/cafef00d", ob_be, ob_wdata); end
    endtask

    task automatic test_fault;
        logic [1:0]  sz [3];
        logic [31:0] ad [3];
        logic        rose;
        sz[0] = 2'b10; ad[0] = 32'h102;
        sz[1] = 2'b01; ad[1] = 32'h13;
        sz[2] = 2'b11; ad[2] = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_size = sz[i]; req_unsigned = 1'b0; req_addr = ad[i];
            #1;
            checks++; if (fault !== 1'b1)      begin errors++; $display("FAIL fault_pulse[%0d]: got %b want 1", i, fault); end
            checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL fault_stall[%0d]: got %b want 0", i, stall); end
            checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL fault_load_data[%0d]: got %h want 0", i, load_data); end
            @(negedge clk);
            req_valid = 1'b0;
            rose = 1'b0;
            for (int c = 0; c < 3; c++) begin
                #1; if (mem_req || fault) rose = 1'b1;
                @(negedge clk);
            end
            checks++; if (rose !== 1'b0) begin errors++; $display("FAIL fault_no_access[%0d]: mem_req/fault seen %b want 0", i, rose); end
        end
    endtask

    task automatic test_wait_states;
        run_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0BAD_F00D, 5);
        checks++; if (ob_busy != 6)            begin errors++; $display("FAIL wait_busy_cycles: got %0d want 6", ob_busy); end
        checks++; if (ob_stable !== 1'b1)      begin errors++; $display("FAIL wait_stable: got %b want 1", ob_stable); end
        checks++; if (ob_stall_cycles != 7)    begin errors++; $display("FAIL wait_stall_cycles: got %0d want 7", ob_stall_cycles); end
        checks++; if (ob_latency != 8)         begin errors++; $display("FAIL wait_latency: got %0d want 8", ob_latency); end
        checks++; if (ob_ld !== 32'h0BAD_F00D || ob_lv !== 1'b1) begin errors++; $display("FAIL wait_load: got %h/%b want 0badf00d/1", ob_ld, ob_lv); end
    endtask

    task automatic test_reset_mid_busy;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h500; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstb_busy: mem_req %b want 1", mem_req); end
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstb_async_req: got %b want 0", mem_req); end
        checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL rstb_async_stall: got %b want 0", stall); end
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rstb_not_retried: req/stall %b%b want 00", mem_req, stall); end
        run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        checks++; if (ob_addr !== 32'h100 || ob_be !== 4'b0000) begin errors++; $display("FAIL rstb_next_req: got %h/%b want 00000100/0000", ob_addr, ob_be); end
        checks++; if (ob_ld !== 32'hDEAD_BEEF || ob_lv !== 1'b1 || ob_latency != 3) begin errors++; $display("FAIL rstb_next_load: got %h/%b/%0d want deadbeef/1/3", ob_ld, ob_lv, ob_latency); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_fault();
        test_wait_states();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
